// File: rtl/snitch_icache_lfsr_checker.sv
// Checks a received LFSR sequence: hunts for a seed, syncs on consecutive matches,
// then free-runs and counts mismatches while locked.
module snitch_icache_lfsr_checker #(
  parameter int unsigned N         = 8,
  parameter int unsigned LockCount = 4,
  parameter int unsigned LossCount = 2,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                valid_i,
  input  logic [N-1:0]        value_i,
  input  logic                clear_i,
  output logic                locked_o,
  output logic                err_o,
  output logic [CntWidth-1:0] err_cnt_o
);

  localparam int unsigned MatchW = $clog2(LockCount + 1);
  localparam int unsigned MissW  = $clog2(LossCount + 1);

`ifndef SYNTHESIS
  if (N < 1 || N > 32) begin : gen_bad_width
    $error("snitch_icache_lfsr_checker: N must be in 1..32");
  end
  if (LockCount < 1) begin : gen_bad_lock
    $error("snitch_icache_lfsr_checker: LockCount must be >= 1");
  end
  if (LossCount < 1) begin : gen_bad_loss
    $error("snitch_icache_lfsr_checker: LossCount must be >= 1");
  end
`endif

  // Feedback tap masks for a right-shifting Galois LFSR of each supported width.
  function automatic logic [31:0] tap_mask(input int unsigned width);
    case (width)
      2:       return 32'h0000_0003;
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0E08;
      13:      return 32'h0000_1C80;
      14:      return 32'h0000_3802;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0007_2000;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0000;
    endcase
  endfunction

  localparam logic [N-1:0] TapMask = N'(tap_mask(N));

  // All-zero maps into the sequence and all-ones maps back out, so the
  // sequence covers every N-bit value.
  function automatic logic [N-1:0] lfsr_next(input logic [N-1:0] x);
    logic [N-1:0] d;
    if (N == 1) return ~x;
    if (x == '0) return '1;
    d = x >> 1;
    if (x[0]) d = d ^ TapMask;
    if (d == '1) d = '0;
    return d;
  endfunction

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StSync   = 2'd1,
    StLocked = 2'd2
  } state_e;

  state_e              state_q;
  logic [N-1:0]        exp_q;
  logic [MatchW-1:0]   match_cnt_q;
  logic [MissW-1:0]    miss_cnt_q;
  logic                locked_q;
  logic                err_q;
  logic [CntWidth-1:0] err_cnt_q;

  logic [N-1:0] value_nxt;
  logic [N-1:0] exp_nxt;
  logic         match;

  always_comb begin
    value_nxt = lfsr_next(value_i);
    exp_nxt   = lfsr_next(exp_q);
    match     = (value_i == exp_q);
  end

  // Hunt / sync / locked tracking; clear wins over a same-cycle sample.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StHunt;
      exp_q       <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      err_q <= 1'b0;
      if (clear_i) begin
        state_q     <= StHunt;
        locked_q    <= 1'b0;
        match_cnt_q <= '0;
        miss_cnt_q  <= '0;
        err_cnt_q   <= '0;
      end else if (valid_i) begin
        unique case (state_q)
          StHunt: begin
            exp_q       <= value_nxt;
            match_cnt_q <= '0;
            state_q     <= StSync;
          end
          StSync: begin
            exp_q <= value_nxt;
            if (match) begin
              match_cnt_q <= match_cnt_q + MatchW'(1);
              if (match_cnt_q == MatchW'(LockCount - 1)) begin
                state_q    <= StLocked;
                locked_q   <= 1'b1;
                miss_cnt_q <= '0;
              end
            end else begin
              match_cnt_q <= '0;
            end
          end
          StLocked: begin
            exp_q <= exp_nxt;
            if (match) begin
              miss_cnt_q <= '0;
            end else begin
              err_q      <= 1'b1;
              miss_cnt_q <= miss_cnt_q + MissW'(1);
              if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CntWidth'(1);
              if (miss_cnt_q == MissW'(LossCount - 1)) begin
                state_q  <= StHunt;
                locked_q <= 1'b0;
              end
            end
          end
          default: begin
            state_q  <= StHunt;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked_o  = locked_q;
  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_snitch_icache_lfsr_checker.sv
// Directed bench for the LFSR checker; a second instance with a 2-bit counter
// covers saturation. Sequence (N=8): 00 FF C7 DB D5 D2 69 8C 46 23 A9 EC 76 3B.
module tb_snitch_icache_lfsr_checker;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       valid_i;
  logic [7:0] value_i;
  logic       clear_i;
  logic       locked_o, err_o;
  logic [15:0] err_cnt_o;
  logic       locked_s, err_s;
  logic [1:0] err_cnt_s;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  snitch_icache_lfsr_checker #(.N(8), .LockCount(4), .LossCount(2), .CntWidth(16)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .value_i  (value_i),
    .clear_i  (clear_i),
    .locked_o (locked_o),
    .err_o    (err_o),
    .err_cnt_o(err_cnt_o)
  );

  snitch_icache_lfsr_checker #(.N(8), .LockCount(4), .LossCount(2), .CntWidth(2)) dut_sat (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .value_i  (value_i),
    .clear_i  (clear_i),
    .locked_o (locked_s),
    .err_o    (err_s),
    .err_cnt_o(err_cnt_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] val, input logic clr);
    valid_i = v;
    value_i = val;
    clear_i = clr;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    clear_i = 1'b0;
  endtask

  // Checks both instances; the 2-bit counter must hold at 3.
  task automatic expect_out(input string tag, input logic lk, input logic er, input int cnt);
    check({tag, ".locked"}, 32'(locked_o), 32'(lk));
    check({tag, ".err"}, 32'(err_o), 32'(er));
    check({tag, ".cnt"}, 32'(err_cnt_o), 32'(cnt));
    check({tag, ".s_locked"}, 32'(locked_s), 32'(lk));
    check({tag, ".s_err"}, 32'(err_s), 32'(er));
    check({tag, ".s_cnt"}, 32'(err_cnt_s), (cnt > 3) ? 32'd3 : 32'(cnt));
  endtask

  task automatic feed(input string tag, input logic [7:0] val, input logic lk,
                      input logic er, input int cnt);
    step(1'b1, val, 1'b0);
    expect_out(tag, lk, er, cnt);
  endtask

  initial begin
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    clear_i = 1'b0;
    value_i = 8'h00;
    #1;
    expect_out("reset", 1'b0, 1'b0, 0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Lock on the first five values of the sequence
    feed("lock0", 8'h00, 1'b0, 1'b0, 0);
    feed("lock1", 8'hFF, 1'b0, 1'b0, 0);
    feed("lock2", 8'hC7, 1'b0, 1'b0, 0);
    feed("lock3", 8'hDB, 1'b0, 1'b0, 0);
    feed("lock4", 8'hD5, 1'b1, 1'b0, 0);

    // Single error, then the free-running expectation continues
    feed("err1", 8'h55, 1'b1, 1'b1, 1);
    feed("err1_ok", 8'h69, 1'b1, 1'b0, 1);

    // Clear with a mismatching sample while locked: no error pulse
    step(1'b1, 8'h00, 1'b1);
    expect_out("clear1", 1'b0, 1'b0, 0);

    // Relock from a mid-sequence seed, then lose lock on two misses
    feed("rl0", 8'hC7, 1'b0, 1'b0, 0);
    feed("rl1", 8'hDB, 1'b0, 1'b0, 0);
    feed("rl2", 8'hD5, 1'b0, 1'b0, 0);
    feed("rl3", 8'hD2, 1'b0, 1'b0, 0);
    feed("rl4", 8'h69, 1'b1, 1'b0, 0);
    feed("loss0", 8'h00, 1'b1, 1'b1, 1);
    feed("loss1", 8'h00, 1'b0, 1'b1, 2);
    step(1'b0, 8'h00, 1'b0);
    expect_out("idle", 1'b0, 1'b0, 2);

    // SYNC reseed on 12, idle cycle mid-sync ignored
    feed("rs0", 8'h00, 1'b0, 1'b0, 2);
    feed("rs1", 8'hFF, 1'b0, 1'b0, 2);
    feed("rs2", 8'h12, 1'b0, 1'b0, 2);
    feed("rs3", 8'h09, 1'b0, 1'b0, 2);
    step(1'b0, 8'h55, 1'b0);
    expect_out("rs_idle", 1'b0, 1'b0, 2);
    feed("rs4", 8'hBC, 1'b0, 1'b0, 2);
    feed("rs5", 8'h5E, 1'b0, 1'b0, 2);
    feed("rs6", 8'h2F, 1'b1, 1'b0, 2);

    // Five locked errors separated by matches
    step(1'b1, 8'h00, 1'b1);
    expect_out("clear2", 1'b0, 1'b0, 0);
    feed("sl0", 8'h00, 1'b0, 1'b0, 0);
    feed("sl1", 8'hFF, 1'b0, 1'b0, 0);
    feed("sl2", 8'hC7, 1'b0, 1'b0, 0);
    feed("sl3", 8'hDB, 1'b0, 1'b0, 0);
    feed("sl4", 8'hD5, 1'b1, 1'b0, 0);
    feed("sat_e1", 8'h00, 1'b1, 1'b1, 1);
    feed("sat_m1", 8'h69, 1'b1, 1'b0, 1);
    feed("sat_e2", 8'h00, 1'b1, 1'b1, 2);
    feed("sat_m2", 8'h46, 1'b1, 1'b0, 2);
    feed("sat_e3", 8'h00, 1'b1, 1'b1, 3);
    feed("sat_m3", 8'hA9, 1'b1, 1'b0, 3);
    feed("sat_e4", 8'h00, 1'b1, 1'b1, 4);
    feed("sat_m4", 8'h76, 1'b1, 1'b0, 4);
    feed("sat_e5", 8'h00, 1'b1, 1'b1, 5);

    // Clear with valid C7: if C7 seeded, lock would come one sample early
    step(1'b1, 8'hC7, 1'b1);
    expect_out("clear3", 1'b0, 1'b0, 0);
    feed("cs0", 8'hDB, 1'b0, 1'b0, 0);
    feed("cs1", 8'hD5, 1'b0, 1'b0, 0);
    feed("cs2", 8'hD2, 1'b0, 1'b0, 0);
    feed("cs3", 8'h69, 1'b0, 1'b0, 0);
    feed("cs4", 8'h8C, 1'b1, 1'b0, 0);

    // Asynchronous reset while locked with an error pulse in flight
    feed("pre_rst", 8'h00, 1'b1, 1'b1, 1);
    rst_ni = 1'b0;
    #2;
    expect_out("async_rst", 1'b0, 1'b0, 0);
    #2;
    rst_ni = 1'b1;
    feed("ar0", 8'h23, 1'b0, 1'b0, 0);
    feed("ar1", 8'hA9, 1'b0, 1'b0, 0);
    feed("ar2", 8'hEC, 1'b0, 1'b0, 0);
    feed("ar3", 8'h76, 1'b0, 1'b0, 0);
    feed("ar4", 8'h3B, 1'b1, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snitch_icache_lfsr_checker.md
SNITCH_ICACHE_LFSR_CHECKER -- requirements
Module: snitch_icache_lfsr_checker

Interface
REQ-001 SHALL have parameter N, default 8: LFSR value width; legal range 1..32, with an elaboration-time assertion outside synthesis.
REQ-002 SHALL have parameter LockCount, default 4: consecutive matches required to lock; must be >= 1.
REQ-003 SHALL have parameter LossCount, default 2: consecutive mismatches while locked that cause loss of lock; must be >= 1.
REQ-004 SHALL have parameter CntWidth, default 16: error counter width.
REQ-005 SHALL have port clk_i, input, 1 bit: clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port valid_i, input, 1 bit: value_i carries a sample this cycle.
REQ-008 SHALL have port value_i, input, N bits: received LFSR value.
REQ-009 SHALL have port clear_i, input, 1 bit: synchronous clear of the lock state and the error counter.
REQ-010 SHALL have port locked_o, output, 1 bit: high while in state LOCKED.
REQ-011 SHALL have port err_o, output, 1 bit: registered one-cycle pulse per mismatch while locked.
REQ-012 SHALL have port err_cnt_o, output, CntWidth bits: saturating count of locked mismatches.

Function
REQ-013 SHALL compute next(x) combinationally for N=1 as ~x.
REQ-014 SHALL compute next(x) combinationally for N>=2 as follows: if x==0, result all-ones; else d = x>>1, XOR taps when x[0]=1, and if d==all-ones, result 0.
REQ-015 SHALL use these tap bit positions: 2:{1,0} 3:{2,1} 4:{3,2} 5:{4,2} 6:{5,4} 7:{6,5} 8:{7,5,4,3} 9:{8,4} 10:{9,6} 11:{10,8}.
REQ-016 SHALL use these tap bit positions: 12:{11,10,9,3} 13:{12,11,10,7} 14:{13,12,11,1} 15:{14,13} 16:{15,14,12,3} 17:{16,13} 18:{17,10} 19:{18,17,16,13}.
REQ-017 SHALL use these tap bit positions: 20:{19,16} 21:{20,18} 22:{21,20} 23:{22,17} 24:{23,22,21,16} 25:{24,21} 26:{25,5,1,0} 27:{26,4,1,0}.
REQ-018 SHALL use these tap bit positions: 28:{27,24} 29:{28,26} 30:{29,5,3,0} 31:{30,27} 32:{31,21,1,0}.
REQ-019 SHALL implement FSM states HUNT, SYNC and LOCKED, plus registers exp[N-1:0], match_cnt (counts to LockCount) and miss_cnt (counts to LossCount).
REQ-020 SHALL ignore cycles with valid_i=0: no state change, err_o=0.
REQ-021 SHALL, in HUNT on a valid sample: set exp<=next(value_i), match_cnt<=0, and go to SYNC.
REQ-022 SHALL, in SYNC on a valid sample with value_i==exp: increment match_cnt and set exp<=next(value_i); when the incremented count equals LockCount, go to LOCKED with miss_cnt<=0.
REQ-023 SHALL, in SYNC on a valid sample with value_i!=exp: reseed exp<=next(value_i), set match_cnt<=0, and stay in SYNC; err_o and err_cnt_o SHALL be unaffected.
REQ-024 SHALL, in LOCKED, free-run exp<=next(exp) on every valid sample regardless of match; value_i SHALL never reseed exp.
REQ-025 SHALL, in LOCKED on a match: set miss_cnt<=0.
REQ-026 SHALL, in LOCKED on a mismatch: set err_o=1 next cycle, increment err_cnt_o saturating at all-ones, and increment miss_cnt; when the incremented miss_cnt equals LossCount, go to HUNT.
REQ-027 SHALL give clear_i priority over valid_i: next state HUNT, err_cnt_o<=0, err_o<=0, match_cnt and miss_cnt <=0, and the same-cycle sample discarded.
REQ-028 SHALL drive locked_o from the registered state, asserting one cycle after the locking sample.
REQ-029 SHALL never wrap err_cnt_o; at all-ones further errors still pulse err_o.
REQ-030 SHALL accept back-to-back valid samples at one per cycle, with no stall or ready signal.

Reset
REQ-031 SHALL, on rst_ni=0 asynchronously, set state HUNT, exp=0, match_cnt=0, miss_cnt=0, locked_o=0, err_o=0, err_cnt_o=0.
REQ-032 SHALL behave as from reset after rst_ni deasserts, discarding any partial sync; the first valid sample after reset seeds exp.

Verification (N=8, LockCount=4, LossCount=2; sequence 00,FF,C7,DB,D5,D2)
REQ-033 SHALL verify lock: feed 00,FF,C7,DB,D5 back-to-back -> locked_o=1 the cycle after D5; err_o never pulses.
REQ-034 SHALL verify single error: after lock feed 55 in place of D2, then next(D2) -> one err_o pulse, err_cnt_o=1, locked_o stays 1.
REQ-035 SHALL verify loss of lock: after lock feed two consecutive wrong values -> err_cnt_o=2 and locked_o=0 the cycle after the second.
REQ-036 SHALL verify SYNC reseed: feed 00,FF,12,then next(12), next(next(12)), ... -> no err_o; locked_o rises only after 4 consecutive matches following 12.
REQ-037 SHALL verify clear and saturation: with CntWidth=2 force 5 locked errors -> err_cnt_o=3, err_o pulses 5 times; then clear_i with valid_i=1 -> err_cnt_o=0, locked_o=0, sample ignored.
REQ-038 SHALL verify reset mid-lock: assert rst_ni=0 while LOCKED -> all outputs 0 immediately (asynchronously); relock requires a new seed plus 4 matches.
